// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position scheduler: steps pos_x/pos_y every step_div+1 frames
// with edge bounce, and applies handshaked config only at frame boundaries. Define SPRITE_WRAP_EN for wrap-around motion.
module sprite_motion_ctrl #(
    parameter int X_MAX = 500,
    parameter int Y_MAX = 440,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          enable,
    input  logic [7:0]    step_div,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [XW-1:0] cfg_x,
    input  logic [YW-1:0] cfg_y,
    input  logic [3:0]    cfg_speed,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          dir_x,
    output logic          dir_y,
    output logic          pos_upd,
    output logic          cfg_pending
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [XW:0] X_LIM = (XW+1)'(X_MAX);
    localparam logic [YW:0] Y_LIM = (YW+1)'(Y_MAX);

    state_t state, state_nxt;

    logic [3:0]    speed;
    logic [7:0]    fcnt;
    logic [XW-1:0] sh_x;
    logic [YW-1:0] sh_y;
    logic [3:0]    sh_speed;

    logic [XW:0]   sum_x, spd_x;
    logic [YW:0]   sum_y, spd_y;
    logic [XW-1:0] x_step, x_cfg;
    logic [YW-1:0] y_step, y_cfg;
    logic          dx_step, dy_step;
    logic          accept;

    // Ready simply mirrors the single-entry shadow being empty.
    assign cfg_ready = ~cfg_pending;
    assign accept    = cfg_valid & cfg_ready;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (enable) state_nxt = S_RUN;
        else        state_nxt = S_IDLE;
    end

    // Next-step position per axis, computed one bit wider so pos+speed cannot overflow.
    always_comb begin
        spd_x   = (XW+1)'(speed);
        spd_y   = (YW+1)'(speed);
        sum_x   = {1'b0, pos_x} + spd_x;
        sum_y   = {1'b0, pos_y} + spd_y;
        x_step  = pos_x;
        y_step  = pos_y;
        dx_step = dir_x;
        dy_step = dir_y;
`ifdef SPRITE_WRAP_EN
        dx_step = 1'b0;
        dy_step = 1'b0;
        if (sum_x > X_LIM) x_step = XW'(sum_x - X_LIM - 1'b1);
        else               x_step = sum_x[XW-1:0];
        if (sum_y > Y_LIM) y_step = YW'(sum_y - Y_LIM - 1'b1);
        else               y_step = sum_y[YW-1:0];
`else
        if (speed != 4'd0) begin
            if (!dir_x) begin
                if (sum_x >= X_LIM) begin
                    x_step  = X_LIM[XW-1:0];
                    dx_step = 1'b1;
                end else begin
                    x_step = sum_x[XW-1:0];
                end
            end else if ({1'b0, pos_x} <= spd_x) begin
                x_step  = '0;
                dx_step = 1'b0;
            end else begin
                x_step = pos_x - spd_x[XW-1:0];
            end

            if (!dir_y) begin
                if (sum_y >= Y_LIM) begin
                    y_step  = Y_LIM[YW-1:0];
                    dy_step = 1'b1;
                end else begin
                    y_step = sum_y[YW-1:0];
                end
            end else if ({1'b0, pos_y} <= spd_y) begin
                y_step  = '0;
                dy_step = 1'b0;
            end else begin
                y_step = pos_y - spd_y[YW-1:0];
            end
        end
`endif
    end

    always_comb begin
        x_cfg = sh_x;
        y_cfg = sh_y;
        if ({1'b0, sh_x} > X_LIM) x_cfg = X_LIM[XW-1:0];
        if ({1'b0, sh_y} > Y_LIM) y_cfg = Y_LIM[YW-1:0];
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x       <= '0;
            pos_y       <= '0;
            dir_x       <= 1'b0;
            dir_y       <= 1'b0;
            speed       <= 4'd1;
            fcnt        <= 8'd0;
            pos_upd     <= 1'b0;
            cfg_pending <= 1'b0;
            sh_x        <= '0;
            sh_y        <= '0;
            sh_speed    <= 4'd0;
        end else begin
            pos_upd <= 1'b0;
            if (accept) begin
                sh_x     <= cfg_x;
                sh_y     <= cfg_y;
                sh_speed <= cfg_speed;
            end
            // A pending config owns the frame boundary; no motion step that frame.
            if (frame_start && cfg_pending) begin
                pos_x       <= x_cfg;
                pos_y       <= y_cfg;
                speed       <= sh_speed;
                dir_x       <= 1'b0;
                dir_y       <= 1'b0;
                fcnt        <= 8'd0;
                pos_upd     <= 1'b1;
                cfg_pending <= 1'b0;
            end else begin
                if (accept) cfg_pending <= 1'b1;
                if (frame_start && state == S_RUN) begin
                    if (fcnt >= step_div) begin
                        fcnt    <= 8'd0;
                        pos_x   <= x_step;
                        pos_y   <= y_step;
                        dir_x   <= dx_step;
                        dir_y   <= dy_step;
                        pos_upd <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed self-checking bench for sprite_motion_ctrl (default bounce build).
module tb_sprite_motion_ctrl;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] step_div = 8'd0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [9:0] cfg_x = '0;
    logic [9:0] cfg_y = '0;
    logic [3:0] cfg_speed = '0;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       dir_x, dir_y, pos_upd, cfg_pending;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    sprite_motion_ctrl dut (
        .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
        .step_div(step_div), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_speed(cfg_speed),
        .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
        .pos_upd(pos_upd), .cfg_pending(cfg_pending)
    );

    always #5 pclk = ~pclk;

    // Counts pos_upd pulses as seen just before each rising edge.
    always @(posedge pclk) if (pos_upd === 1'b1) upd_cnt++;

    task automatic frame();
        @(negedge pclk) frame_start = 1'b1;
        @(negedge pclk) frame_start = 1'b0;
    endtask

    task automatic send_cfg(input logic [9:0] x, input logic [9:0] y, input logic [3:0] s);
        @(negedge pclk);
        cfg_valid = 1'b1; cfg_x = x; cfg_y = y; cfg_speed = s;
        @(negedge pclk) cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge pclk);
        n_checks++;
        if (pos_x !== 10'd0 || pos_y !== 10'd0 || dir_x !== 1'b0 || dir_y !== 1'b0 ||
            pos_upd !== 1'b0 || cfg_pending !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: pos=(%0d,%0d) dir=%b%b upd=%b pend=%b rdy=%b expected (0,0) 00 0 0 1",
                     pos_x, pos_y, dir_x, dir_y, pos_upd, cfg_pending, cfg_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_step_every_frame();
        @(negedge pclk) enable = 1'b1;
        @(negedge pclk) upd_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            frame();
            n_checks++;
            if (pos_x !== 10'(i) || pos_y !== 10'(i) || pos_upd !== 1'b1 || dir_x !== 1'b0) begin
                n_fail++;
                $display("FAIL step_frame%0d: pos=(%0d,%0d) upd=%b dir_x=%b expected (%0d,%0d) 1 0",
                         i, pos_x, pos_y, pos_upd, dir_x, i, i);
            end
        end
        repeat (2) @(negedge pclk);
        n_checks++;
        if (upd_cnt !== 3) begin
            n_fail++;
            $display("FAIL step_upd_count: got %0d expected 3", upd_cnt);
        end
    endtask

    task automatic test_bounce_right();
        send_cfg(10'd499, 10'd10, 4'd4);
        frame();
        n_checks++;
        if (pos_x !== 10'd499 || pos_y !== 10'd10 || pos_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_apply: pos=(%0d,%0d) upd=%b expected (499,10) 1", pos_x, pos_y, pos_upd);
        end
        frame();
        n_checks++;
        if (pos_x !== 10'd500 || pos_y !== 10'd14 || dir_x !== 1'b1 || dir_y !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_edge: pos=(%0d,%0d) dir=%b%b expected (500,14) 10", pos_x, pos_y, dir_x, dir_y);
        end
        frame();
        n_checks++;
        if (pos_x !== 10'd496 || pos_y !== 10'd18 || dir_x !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_back: pos=(%0d,%0d) dir_x=%b expected (496,18) 1", pos_x, pos_y, dir_x);
        end
    endtask

    task automatic test_step_div();
        step_div = 8'd2;
        send_cfg(10'd0, 10'd0, 4'd1);
        frame();
        @(negedge pclk) upd_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            frame();
            if (i == 3 || i == 6) begin
                n_checks++;
                if (pos_x !== 10'(i / 3) || pos_y !== 10'(i / 3) || pos_upd !== 1'b1) begin
                    n_fail++;
                    $display("FAIL div_frame%0d: pos=(%0d,%0d) upd=%b expected (%0d,%0d) 1",
                             i, pos_x, pos_y, pos_upd, i / 3, i / 3);
                end
            end
        end
        repeat (2) @(negedge pclk);
        n_checks++;
        if (upd_cnt !== 2) begin
            n_fail++;
            $display("FAIL div_upd_count: got %0d expected 2", upd_cnt);
        end
        step_div = 8'd0;
    endtask

    task automatic test_handshake();
        @(negedge pclk) enable = 1'b0;
        @(negedge pclk);
        cfg_valid = 1'b1; cfg_x = 10'd100; cfg_y = 10'd200; cfg_speed = 4'd2;
        @(negedge pclk);
        n_checks++;
        if (cfg_ready !== 1'b0 || cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_accept: rdy=%b pend=%b expected 0 1", cfg_ready, cfg_pending);
        end
        cfg_x = 10'd50; cfg_y = 10'd60; cfg_speed = 4'd3;
        repeat (3) @(negedge pclk);
        frame();
        n_checks++;
        if (pos_x !== 10'd100 || pos_y !== 10'd200 || pos_upd !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_first_applied: pos=(%0d,%0d) upd=%b rdy=%b expected (100,200) 1 1",
                     pos_x, pos_y, pos_upd, cfg_ready);
        end
        @(negedge pclk);
        n_checks++;
        if (cfg_ready !== 1'b0 || cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_second_accept: rdy=%b pend=%b expected 0 1", cfg_ready, cfg_pending);
        end
        cfg_valid = 1'b0;
        frame();
        n_checks++;
        if (pos_x !== 10'd50 || pos_y !== 10'd60) begin
            n_fail++;
            $display("FAIL hs_second_applied: pos=(%0d,%0d) expected (50,60)", pos_x, pos_y);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge pclk) enable = 1'b1;
        @(negedge pclk);
        frame_start = 1'b1; cfg_valid = 1'b1;
        cfg_x = 10'd300; cfg_y = 10'd310; cfg_speed = 4'd5;
        @(negedge pclk);
        frame_start = 1'b0; cfg_valid = 1'b0;
        n_checks++;
        if (pos_x !== 10'd53 || pos_y !== 10'd63 || pos_upd !== 1'b1 || cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_step: pos=(%0d,%0d) upd=%b pend=%b expected (53,63) 1 1",
                     pos_x, pos_y, pos_upd, cfg_pending);
        end
        frame();
        n_checks++;
        if (pos_x !== 10'd300 || pos_y !== 10'd310 || cfg_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_apply: pos=(%0d,%0d) pend=%b expected (300,310) 0",
                     pos_x, pos_y, cfg_pending);
        end
        frame();
        n_checks++;
        if (pos_x !== 10'd305 || pos_y !== 10'd315) begin
            n_fail++;
            $display("FAIL same_cycle_speed: pos=(%0d,%0d) expected (305,315)", pos_x, pos_y);
        end
    endtask

    task automatic test_clamp_and_left_bounce();
        send_cfg(10'd700, 10'd0, 4'd15);
        frame();
        n_checks++;
        if (pos_x !== 10'd500 || pos_y !== 10'd0) begin
            n_fail++;
            $display("FAIL clamp_x: pos=(%0d,%0d) expected (500,0)", pos_x, pos_y);
        end
        repeat (34) frame();
        n_checks++;
        if (pos_x !== 10'd5 || dir_x !== 1'b1 || pos_y !== 10'd380 || dir_y !== 1'b1) begin
            n_fail++;
            $display("FAIL near_left: pos=(%0d,%0d) dir=%b%b expected (5,380) 11", pos_x, pos_y, dir_x, dir_y);
        end
        frame();
        n_checks++;
        if (pos_x !== 10'd0 || dir_x !== 1'b0 || pos_y !== 10'd365 || dir_y !== 1'b1) begin
            n_fail++;
            $display("FAIL left_bounce: pos=(%0d,%0d) dir=%b%b expected (0,365) 01", pos_x, pos_y, dir_x, dir_y);
        end
    endtask

    task automatic test_idle_apply();
        @(negedge pclk) enable = 1'b0;
        send_cfg(10'd20, 10'd30, 4'd2);
        frame();
        n_checks++;
        if (pos_x !== 10'd20 || pos_y !== 10'd30 || pos_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_apply: pos=(%0d,%0d) upd=%b expected (20,30) 1", pos_x, pos_y, pos_upd);
        end
        frame();
        n_checks++;
        if (pos_x !== 10'd20 || pos_y !== 10'd30 || pos_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: pos=(%0d,%0d) upd=%b expected (20,30) 0", pos_x, pos_y, pos_upd);
        end
    endtask

    task automatic test_async_reset();
        send_cfg(10'd40, 10'd50, 4'd1);
        @(negedge pclk);
        n_checks++;
        if (cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pending_before: pend=%b expected 1", cfg_pending);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (pos_x !== 10'd0 || pos_y !== 10'd0 || dir_x !== 1'b0 || dir_y !== 1'b0 ||
            pos_upd !== 1'b0 || cfg_pending !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_immediate: pos=(%0d,%0d) dir=%b%b upd=%b pend=%b rdy=%b expected (0,0) 00 0 0 1",
                     pos_x, pos_y, dir_x, dir_y, pos_upd, cfg_pending, cfg_ready);
        end
        @(negedge pclk) rst_n = 1'b1;
        frame();
        n_checks++;
        if (pos_x !== 10'd0 || pos_y !== 10'd0 || pos_upd !== 1'b0 || cfg_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_discard: pos=(%0d,%0d) upd=%b pend=%b expected (0,0) 0 0",
                     pos_x, pos_y, pos_upd, cfg_pending);
        end
    endtask

    initial begin
        test_reset();
        test_step_every_frame();
        test_bounce_right();
        test_step_div();
        test_handshake();
        test_same_cycle();
        test_clamp_and_left_bounce();
        test_idle_apply();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
